// File: rtl/mist1032isa_mem_pkg.sv
// Shared encodings and lane helpers for the data-memory requester.
// Byte offset 0 is the most significant lane of a 32-bit word (big-endian lanes).
package mist1032isa_mem_pkg;

  typedef enum logic [1:0] {
    ORDER_BYTE = 2'b00,
    ORDER_HALF = 2'b01,
    ORDER_WORD = 2'b10,
    ORDER_NONE = 2'b11
  } order_e;

  localparam logic [3:0] MASK_BYTE0   = 4'b1000;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_WORD    = 4'b1111;
  localparam logic [3:0] MASK_NONE    = 4'b0000;

  // Tag layout: {ADDR[2:0], ORDER}; ADDR[2] picks the half of the returned line.
  localparam int TAG_W = 5;

  function automatic logic func_misaligned(input logic [1:0] order, input logic [1:0] off);
    case (order)
      ORDER_BYTE: func_misaligned = 1'b0;
      ORDER_HALF: func_misaligned = off[0];
      ORDER_WORD: func_misaligned = (off != 2'b00);
      default:    func_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] func_lane_mask(input logic [1:0] order, input logic [1:0] off);
    case (order)
      ORDER_BYTE: func_lane_mask = MASK_BYTE0 >> off;
      ORDER_HALF: func_lane_mask = off[1] ? MASK_HALF_LO : MASK_HALF_HI;
      ORDER_WORD: func_lane_mask = MASK_WORD;
      default:    func_lane_mask = MASK_NONE;
    endcase
  endfunction

  function automatic logic [31:0] func_lane_data(input logic [1:0] order, input logic [1:0] off,
                                                 input logic [31:0] data);
    case (order)
      ORDER_BYTE: func_lane_data = {24'h0, data[7:0]} << {2'd3 - off, 3'b000};
      ORDER_HALF: func_lane_data = off[1] ? {16'h0, data[15:0]} : {data[15:0], 16'h0};
      ORDER_WORD: func_lane_data = data;
      default:    func_lane_data = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] func_extract(input logic [63:0] line, input logic [TAG_W-1:0] tag);
    logic [31:0] word;
    word = tag[4] ? line[63:32] : line[31:0];
    case (tag[1:0])
      ORDER_BYTE: func_extract = (word >> {2'd3 - tag[3:2], 3'b000}) & 32'h0000_00FF;
      ORDER_HALF: func_extract = tag[3] ? (word & 32'h0000_FFFF) : (word >> 16);
      ORDER_WORD: func_extract = word;
      default:    func_extract = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/mist1032isa_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; writes when full and reads
// when empty are ignored.
module mist1032isa_sync_fifo #(
  parameter int P_N       = 16,
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
)(
  input  logic           iCLOCK,
  input  logic           inRESET,
  input  logic           iWR_EN,
  input  logic [P_N-1:0] iWR_DATA,
  output logic           oWR_FULL,
  input  logic           iRD_EN,
  output logic [P_N-1:0] oRD_DATA,
  output logic           oRD_EMPTY
);

  logic [P_DEPTH_N:0] r_wr_ptr;
  logic [P_DEPTH_N:0] r_rd_ptr;
  logic [P_N-1:0]     r_mem [P_DEPTH];
  logic               w_wr;
  logic               w_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign oWR_FULL  = (r_wr_ptr[P_DEPTH_N] != r_rd_ptr[P_DEPTH_N]) &&
                     (r_wr_ptr[P_DEPTH_N-1:0] == r_rd_ptr[P_DEPTH_N-1:0]);
  assign oRD_EMPTY = (r_wr_ptr == r_rd_ptr);
  assign w_wr      = iWR_EN && !oWR_FULL;
  assign w_rd      = iRD_EN && !oRD_EMPTY;
  assign oRD_DATA  = r_mem[r_rd_ptr[P_DEPTH_N-1:0]];

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (w_wr) r_mem[r_wr_ptr[P_DEPTH_N-1:0]] <= iWR_DATA;
  end

endmodule

// File: rtl/mist1032isa_memory_requester.sv
// Load/store requester: stages one pipeline request, issues it to the 64-bit
// data memory and returns in-order, zero-extended load data.
module mist1032isa_memory_requester
  import mist1032isa_mem_pkg::*;
#(
  parameter int P_TAG_DEPTH   = 4,
  parameter int P_TAG_DEPTH_N = 2
)(
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iREQ_VALID,
  output logic        oREQ_BUSY,
  input  logic        iREQ_RW,
  input  logic [1:0]  iREQ_ORDER,
  input  logic [25:0] iREQ_ADDR,
  input  logic [31:0] iREQ_DATA,
  output logic        oERR_MISALIGN,
  output logic        oRD_VALID,
  input  logic        iRD_BUSY,
  output logic [31:0] oRD_DATA,
  output logic        oMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  output logic [1:0]  oMEMORY_ORDER,
  output logic [3:0]  oMEMORY_MASK,
  output logic        oMEMORY_RW,
  output logic [25:0] oMEMORY_ADDR,
  output logic [31:0] oMEMORY_DATA,
  input  logic        iMEMORY_VALID,
  output logic        oMEMORY_LOCK,
  input  logic [63:0] iMEMORY_DATA
);

  logic             r_stage_vld_p0;
  logic             r_stage_rw_p0;
  logic [1:0]       r_stage_order_p0;
  logic [25:0]      r_stage_addr_p0;
  logic [3:0]       r_stage_mask_p0;
  logic [31:0]      r_stage_data_p0;
  logic             r_err_p0;
  logic             r_rsp_vld_p1;
  logic [31:0]      r_rsp_data_p1;

  logic             w_misalign;
  logic             w_accept;
  logic             w_mem_req;
  logic             w_fire;
  logic             w_tag_push;
  logic             w_tag_pop;
  logic             w_tag_full;
  logic             w_tag_empty;
  logic             w_mem_lock;
  logic [TAG_W-1:0] w_tag_wr;
  logic [TAG_W-1:0] w_tag_rd;

  assign w_misalign = func_misaligned(iREQ_ORDER, iREQ_ADDR[1:0]);
  // Stores never wait on tag space; reads need a free tag before issuing.
  assign w_mem_req  = r_stage_vld_p0 && (r_stage_rw_p0 || !w_tag_full);
  assign w_fire     = w_mem_req && !iMEMORY_LOCK;
  assign oREQ_BUSY  = r_stage_vld_p0 && !w_fire;
  assign w_accept   = iREQ_VALID && !oREQ_BUSY;

  // ---- stage p0: request register ----
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_stage_vld_p0   <= 1'b0;
      r_stage_rw_p0    <= 1'b0;
      r_stage_order_p0 <= 2'b00;
      r_stage_addr_p0  <= '0;
      r_stage_mask_p0  <= '0;
      r_stage_data_p0  <= '0;
      r_err_p0         <= 1'b0;
    end else begin
      r_err_p0 <= w_accept && w_misalign;
      if (w_accept && !w_misalign) begin
        r_stage_vld_p0   <= 1'b1;
        r_stage_rw_p0    <= iREQ_RW;
        r_stage_order_p0 <= iREQ_ORDER;
        r_stage_addr_p0  <= iREQ_ADDR;
        r_stage_mask_p0  <= func_lane_mask(iREQ_ORDER, iREQ_ADDR[1:0]);
        r_stage_data_p0  <= func_lane_data(iREQ_ORDER, iREQ_ADDR[1:0], iREQ_DATA);
      end else if (w_fire) begin
        r_stage_vld_p0 <= 1'b0;
      end
    end
  end

  assign oMEMORY_REQ   = w_mem_req;
  assign oMEMORY_RW    = r_stage_rw_p0;
  assign oMEMORY_ORDER = r_stage_order_p0;
  assign oMEMORY_ADDR  = r_stage_addr_p0;
  assign oMEMORY_MASK  = r_stage_mask_p0;
  assign oMEMORY_DATA  = r_stage_data_p0;
  assign oERR_MISALIGN = r_err_p0;

  assign w_tag_wr   = {r_stage_addr_p0[2:0], r_stage_order_p0};
  assign w_tag_push = w_fire && !r_stage_rw_p0;
  // Data arriving with no outstanding tag is discarded without popping.
  assign w_tag_pop  = iMEMORY_VALID && !w_tag_empty && !w_mem_lock;
  assign w_mem_lock = r_rsp_vld_p1 && iRD_BUSY;

  mist1032isa_sync_fifo #(
    .P_N       (TAG_W),
    .P_DEPTH   (P_TAG_DEPTH),
    .P_DEPTH_N (P_TAG_DEPTH_N)
  ) u_tag_fifo (
    .iCLOCK    (iCLOCK),
    .inRESET   (inRESET),
    .iWR_EN    (w_tag_push),
    .iWR_DATA  (w_tag_wr),
    .oWR_FULL  (w_tag_full),
    .iRD_EN    (w_tag_pop),
    .oRD_DATA  (w_tag_rd),
    .oRD_EMPTY (w_tag_empty)
  );

  // ---- stage p1: response register ----
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_rsp_vld_p1  <= 1'b0;
      r_rsp_data_p1 <= '0;
    end else if (w_tag_pop) begin
      r_rsp_vld_p1  <= 1'b1;
      r_rsp_data_p1 <= func_extract(iMEMORY_DATA, w_tag_rd);
    end else if (!iRD_BUSY) begin
      r_rsp_vld_p1  <= 1'b0;
    end
  end

  assign oRD_VALID    = r_rsp_vld_p1;
  assign oRD_DATA     = r_rsp_data_p1;
  assign oMEMORY_LOCK = w_mem_lock;

endmodule

// File: tb/tb_mist1032isa_memory_requester.sv
// Scoreboard bench for the memory requester: random and directed traffic
// checked against a byte-lane model of the load/store rules.
module tb_mist1032isa_memory_requester;

  localparam int DEPTH  = 4;
  localparam int PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iREQ_VALID, iREQ_RW, iRD_BUSY, iMEMORY_LOCK, iMEMORY_VALID;
  logic [1:0]  iREQ_ORDER;
  logic [25:0] iREQ_ADDR;
  logic [31:0] iREQ_DATA;
  logic [63:0] iMEMORY_DATA;
  logic        oREQ_BUSY, oERR_MISALIGN, oRD_VALID, oMEMORY_REQ, oMEMORY_RW, oMEMORY_LOCK;
  logic [31:0] oRD_DATA, oMEMORY_DATA;
  logic [1:0]  oMEMORY_ORDER;
  logic [3:0]  oMEMORY_MASK;
  logic [25:0] oMEMORY_ADDR;

  always #(PERIOD/2) clk = ~clk;

  mist1032isa_memory_requester #(.P_TAG_DEPTH(DEPTH), .P_TAG_DEPTH_N(2)) dut (
    .iCLOCK(clk), .inRESET(rst_n),
    .iREQ_VALID(iREQ_VALID), .oREQ_BUSY(oREQ_BUSY), .iREQ_RW(iREQ_RW),
    .iREQ_ORDER(iREQ_ORDER), .iREQ_ADDR(iREQ_ADDR), .iREQ_DATA(iREQ_DATA),
    .oERR_MISALIGN(oERR_MISALIGN), .oRD_VALID(oRD_VALID), .iRD_BUSY(iRD_BUSY),
    .oRD_DATA(oRD_DATA), .oMEMORY_REQ(oMEMORY_REQ), .iMEMORY_LOCK(iMEMORY_LOCK),
    .oMEMORY_ORDER(oMEMORY_ORDER), .oMEMORY_MASK(oMEMORY_MASK), .oMEMORY_RW(oMEMORY_RW),
    .oMEMORY_ADDR(oMEMORY_ADDR), .oMEMORY_DATA(oMEMORY_DATA), .iMEMORY_VALID(iMEMORY_VALID),
    .oMEMORY_LOCK(oMEMORY_LOCK), .iMEMORY_DATA(iMEMORY_DATA)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  order;
    logic [25:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          acc_cyc;
  } req_t;
  typedef struct {
    logic [25:0] addr;
    logic [1:0]  order;
    logic [63:0] line;
  } rd_t;
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  req_t exp_req_q[$];
  rd_t  mem_q[$];
  rsp_t rsp_q[$];
  int   err_q[$];

  int tests = 0, fails = 0, cyc = 0, tags_out = 0, rd_fires = 0;
  int lock_pct = 0, valid_pct = 0, busy_pct = 0;
  bit lock_force = 0, busy_force = 0, fixed_line_en = 0;
  logic [63:0] fixed_line = 64'h0123_4567_89AB_CDEF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (byte-lane view) ----------------
  function automatic int size_of(input logic [1:0] order);
    return (order == 2'd0) ? 1 : (order == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_misaligned(input logic [1:0] order, input logic [25:0] addr);
    return (order == 2'd3) || (order == 2'd1 && addr[0]) || (order == 2'd2 && addr[1:0] != 2'd0);
  endfunction

  function automatic logic [3:0] model_mask(input logic [1:0] order, input logic [25:0] addr);
    int s = size_of(order);
    int o = int'(addr[1:0]);
    logic [3:0] m = 4'h0;
    for (int j = 0; j < s; j++) m[3-(o+j)] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] order, input logic [25:0] addr,
                                              input logic [31:0] data);
    int s = size_of(order);
    int o = int'(addr[1:0]);
    logic [31:0] w = 32'h0;
    for (int j = 0; j < s; j++) w[31-8*(o+j) -: 8] = data[8*(s-1-j) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] order, input logic [25:0] addr,
                                             input logic [63:0] line);
    int s = size_of(order);
    int o = int'(addr[1:0]);
    logic [31:0] w = addr[2] ? line[63:32] : line[31:0];
    logic [31:0] r = 32'h0;
    for (int j = 0; j < s; j++) r[8*(s-1-j) +: 8] = w[31-8*(o+j) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] byte_bits(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // ---------------- stimulus ----------------
  task automatic send(input logic rw, input logic [1:0] order, input logic [25:0] addr,
                      input logic [31:0] data);
    int n = 0;
    bit done = 0;
    iREQ_VALID = 1'b1; iREQ_RW = rw; iREQ_ORDER = order; iREQ_ADDR = addr; iREQ_DATA = data;
    while (!done) begin
      @(negedge clk);
      if (!oREQ_BUSY) begin
        done = 1;
        if (is_misaligned(order, addr)) err_q.push_back(cyc + 1);
        else exp_req_q.push_back('{rw, order, addr, model_mask(order, addr),
                                   model_wdata(order, addr, data), cyc});
      end else if (++n > 300) begin
        done = 1;
        tests++; fails++;
        $display("FAIL accept_timeout: request never accepted (cycle %0d)", cyc);
      end
      @(posedge clk); #1;
    end
    iREQ_VALID = 1'b0;
  endtask

  task automatic send_random();
    logic [31:0] ra, rdat;
    logic [1:0]  ord;
    int          ro;
    ra = $urandom(); rdat = $urandom(); ro = int'($urandom_range(15));
    ord = (ro < 5) ? 2'd0 : (ro < 10) ? 2'd1 : (ro < 15) ? 2'd2 : 2'd3;
    if ($urandom_range(3) != 0) begin
      if (ord == 2'd1) ra[0] = 1'b0;
      if (ord == 2'd2) ra[1:0] = 2'b00;
    end
    send(1'($urandom_range(1)), ord, ra[25:0], rdat);
  endtask

  task automatic drain();
    int n = 0;
    lock_pct = 0; busy_pct = 0; valid_pct = 100; lock_force = 0; busy_force = 0;
    while ((exp_req_q.size() + mem_q.size() + rsp_q.size() + err_q.size()) != 0 && n < 1000) begin
      @(negedge clk); n++;
    end
    if (n >= 1000) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d requests, %0d reads, %0d responses pending",
               exp_req_q.size(), mem_q.size(), rsp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rd(output logic [31:0] d);
    int n = 0;
    bit got = 0;
    d = 32'h0;
    while (!got && n < 60) begin
      @(negedge clk); n++;
      if (oRD_VALID && !iRD_BUSY) begin got = 1; d = oRD_DATA; end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL rd_timeout: no load data returned (cycle %0d)", cyc);
    end
  endtask

  // memory and pipeline-side responder
  initial begin
    iMEMORY_LOCK = 1'b0; iMEMORY_VALID = 1'b0; iMEMORY_DATA = 64'h0; iRD_BUSY = 1'b0;
    forever begin
      @(posedge clk); #1;
      iMEMORY_LOCK = lock_force || (int'($urandom_range(99)) < lock_pct);
      iRD_BUSY     = busy_force || (int'($urandom_range(99)) < busy_pct);
      if (rst_n && mem_q.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
        iMEMORY_VALID = 1'b1;
        iMEMORY_DATA  = mem_q[0].line;
      end else begin
        iMEMORY_VALID = 1'b0;
        iMEMORY_DATA  = {$urandom(), $urandom()};
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit   mon_st, mon_ereq, mon_eerr, mon_ersp, mon_fire;
  req_t mon_h;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_st   = (exp_req_q.size() > 0) && (exp_req_q[0].acc_cyc < cyc);
      mon_ereq = mon_st && (exp_req_q[0].rw || tags_out < DEPTH);
      check("mem_req", oMEMORY_REQ, mon_ereq);
      check("req_busy", oREQ_BUSY, mon_st && !(mon_ereq && !iMEMORY_LOCK));
      if (oMEMORY_REQ && mon_st) begin
        mon_h = exp_req_q[0];
        check("mem_rw", oMEMORY_RW, mon_h.rw);
        check("mem_order", oMEMORY_ORDER, mon_h.order);
        check("mem_addr", oMEMORY_ADDR, mon_h.addr);
        check("mem_mask", oMEMORY_MASK, mon_h.mask);
        if (mon_h.rw) check("mem_wdata", oMEMORY_DATA & byte_bits(mon_h.mask), mon_h.wdata);
      end
      while (err_q.size() > 0 && err_q[0] < cyc) void'(err_q.pop_front());
      mon_eerr = (err_q.size() > 0) && (err_q[0] == cyc);
      check("err_misalign", oERR_MISALIGN, mon_eerr);
      if (mon_eerr) void'(err_q.pop_front());
      mon_ersp = (rsp_q.size() > 0) && (rsp_q[0].cyc < cyc);
      check("rd_valid", oRD_VALID, mon_ersp);
      check("mem_lock", oMEMORY_LOCK, mon_ersp && iRD_BUSY);
      if (oRD_VALID && mon_ersp) check("rd_data", oRD_DATA, rsp_q[0].data);
      if (oRD_VALID && mon_ersp && !iRD_BUSY) void'(rsp_q.pop_front());
      if (iMEMORY_VALID && !oMEMORY_LOCK && mem_q.size() > 0) begin
        rsp_q.push_back('{model_load(mem_q[0].order, mem_q[0].addr, mem_q[0].line), cyc});
        void'(mem_q.pop_front());
        tags_out--;
      end
      mon_fire = oMEMORY_REQ && !iMEMORY_LOCK;
      if (mon_fire && mon_st) begin
        mon_h = exp_req_q.pop_front();
        if (!mon_h.rw) begin
          mem_q.push_back('{mon_h.addr, mon_h.order,
                            fixed_line_en ? fixed_line : {$urandom(), $urandom()}});
          tags_out++;
          rd_fires++;
        end
      end
    end
  end

  initial begin
    #(PERIOD * 60000);
    fails++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    int snap;
    bit found;
    iREQ_VALID = 1'b0; iREQ_RW = 1'b0; iREQ_ORDER = 2'd0; iREQ_ADDR = '0; iREQ_DATA = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_busy", oREQ_BUSY, 0);
    check("rst_mem_req", oMEMORY_REQ, 0);
    check("rst_rd_valid", oRD_VALID, 0);
    check("rst_payload", {oMEMORY_ADDR, oMEMORY_MASK, oMEMORY_ORDER, oMEMORY_RW}, 0);
    check("rst_mem_data", oMEMORY_DATA, 0);
    check("rst_misc", {oERR_MISALIGN, oMEMORY_LOCK, oRD_DATA}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // randomized traffic
    lock_pct = 25; valid_pct = 60; busy_pct = 25;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
      else send_random();
    end
    drain();

    // store byte at offset 1
    send(1'b1, 2'd0, 26'h000005, 32'h0000_0089);
    @(negedge clk);
    check("stb_mask", oMEMORY_MASK, 4'b0100);
    check("stb_lane", oMEMORY_DATA[23:16], 8'h89);
    check("stb_addr", oMEMORY_ADDR, 26'h000005);
    check("stb_rw", oMEMORY_RW, 1'b1);
    drain();

    // loads from a fixed line
    fixed_line_en = 1;
    send(1'b0, 2'd1, 26'h000006, 32'h0);
    send(1'b0, 2'd2, 26'h000000, 32'h0);
    wait_rd(d);
    check("ldh_off6", d, 32'h0000_4567);
    wait_rd(d);
    check("ldw_off0", d, 32'h89AB_CDEF);
    drain();

    // memory lock for three cycles with a store staged
    @(negedge clk); lock_force = 1;
    @(posedge clk); #1;
    send(1'b1, 2'd2, 26'h000100, 32'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lock_busy", oREQ_BUSY, 1);
      check("lock_req", oMEMORY_REQ, 1);
      check("lock_data", oMEMORY_DATA, 32'hDEAD_BEEF);
      if (k == 2) lock_force = 0;
    end
    @(negedge clk);
    check("lock_release_fire", oMEMORY_REQ && !iMEMORY_LOCK, 1);
    drain();

    // tag FIFO full: fifth load waits for a return
    valid_pct = 0;
    snap = rd_fires;
    for (int k = 0; k < 5; k++) send(1'b0, 2'd2, 26'h000040 + 26'(4 * k), 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("full_no_req", oMEMORY_REQ, 0);
      check("full_busy", oREQ_BUSY, 1);
    end
    check("full_issued", rd_fires - snap, 4);
    valid_pct = 100;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (iMEMORY_VALID && !oMEMORY_LOCK) found = 1;
    end
    check("full_return_seen", found, 1);
    @(negedge clk);
    check("full_fifth_issues", oMEMORY_REQ, 1);
    drain();

    // misaligned word load
    send(1'b0, 2'd2, 26'h000002, 32'h0);
    @(negedge clk);
    check("mis_err", oERR_MISALIGN, 1);
    check("mis_no_req", oMEMORY_REQ, 0);
    @(negedge clk);
    check("mis_err_pulse", oERR_MISALIGN, 0);
    drain();

    // pipeline busy holds the response
    @(negedge clk); busy_force = 1;
    @(posedge clk); #1;
    send(1'b0, 2'd2, 26'h000010, 32'h0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (oRD_VALID) found = 1;
    end
    check("busy_rsp_seen", found, 1);
    repeat (3) begin
      @(negedge clk);
      check("busy_lock", oMEMORY_LOCK, 1);
      check("busy_data", oRD_DATA, 32'h89AB_CDEF);
    end
    drain();
    fixed_line_en = 0;

    // asynchronous reset in the middle of a stall
    @(negedge clk); lock_force = 1;
    @(posedge clk); #1;
    send(1'b1, 2'd0, 26'h000003, 32'h0000_0055);
    @(negedge clk);
    check("stall_busy", oREQ_BUSY, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req_busy", oREQ_BUSY, 0);
    check("arst_mem_req", oMEMORY_REQ, 0);
    check("arst_payload", {oMEMORY_ADDR, oMEMORY_MASK, oMEMORY_ORDER, oMEMORY_RW}, 0);
    check("arst_mem_data", oMEMORY_DATA, 0);
    check("arst_misc", {oERR_MISALIGN, oMEMORY_LOCK, oRD_VALID, oRD_DATA}, 0);
    exp_req_q.delete(); mem_q.delete(); rsp_q.delete(); err_q.delete();
    tags_out = 0;
    lock_force = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // recovery traffic
    lock_pct = 20; valid_pct = 70; busy_pct = 20;
    for (int i = 0; i < 150; i++) send_random();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
